// File: rtl/reg_list_encoder_if.sv
// Handshake and result bundle between the LDM/STM control logic and the
// register-list encoder.
interface reg_list_encoder_if #(
    parameter int unsigned LIST_W = 16
);
    logic              start;
    logic [LIST_W-1:0] reg_list;
    logic              advance;
    logic              busy;
    logic              valid;
    logic [3:0]        reg_num;
    logic [4:0]        beat;
    logic              first;
    logic              last;
    logic [4:0]        count;
    logic              done;

    modport master (
        output start, reg_list, advance,
        input  busy, valid, reg_num, beat, first, last, count, done
    );

    modport slave (
        input  start, reg_list, advance,
        output busy, valid, reg_num, beat, first, last, count, done
    );
endinterface

// File: rtl/reg_list_encoder.sv
// Sequential register-list encoder: walks a 16-bit LDM/STM register list
// lowest-first and presents one 4-bit register index per accepted beat.
module reg_list_encoder #(
    parameter int unsigned LIST_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    reg_list_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LIST_W-1:0] remaining;
    logic [4:0]        beat_q;
    logic [4:0]        count_q;
    logic [3:0]        low_idx;
    logic              one_left;
    logic [4:0]        list_pop;
    logic              run;

    assign run = (state == RUN);

    // Lowest set bit of the remaining list; scanning downwards lets the
    // lowest hit overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = LIST_W; i > 0; i--) begin
            if (remaining[i-1]) begin
                low_idx = 4'(i - 1);
            end
        end
    end

    // Exactly one bit left: non-zero and clearing the lowest bit empties it.
    assign one_left = (remaining != '0) &&
                      ((remaining & (remaining - LIST_W'(1))) == '0);

    // Population count of the incoming list, loaded on an accepted start.
    always_comb begin
        list_pop = '0;
        for (int unsigned i = 0; i < LIST_W; i++) begin
            list_pop = list_pop + 5'(bus.reg_list[i]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.reg_list != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.advance && one_left) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // List, beat and count registers: load on start, consume on advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            beat_q    <= '0;
            count_q   <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                remaining <= bus.reg_list;
                count_q   <= list_pop;
                beat_q    <= '0;
            end
        end else if (run && bus.advance) begin
            remaining <= remaining & (remaining - LIST_W'(1));
            beat_q    <= beat_q + 5'd1;
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.valid   = run;
    assign bus.reg_num = run ? low_idx : '0;
    assign bus.beat    = beat_q;
    assign bus.first   = run && (beat_q == '0);
    assign bus.last    = run && one_left;
    assign bus.count   = count_q;
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_reg_list_encoder.sv
// Directed bench for reg_list_encoder with hand-listed expected indices.
module tb_reg_list_encoder;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   exp_q[$];

    reg_list_encoder_if #(.LIST_W(16)) bus ();

    reg_list_encoder #(.LIST_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a list and follow it to completion against exp_q.
    // adv_mode 0: advance always high; 1: advance pattern 1,0,0 repeating.
    // poke: pulse a competing start during RUN, which must be ignored.
    task automatic run_list(input string tag, input logic [15:0] list,
                            input int adv_mode, input bit poke);
        int  k;
        int  cyc;
        bit  done_seen;
        bit  adv;
        int  n;
        n = exp_q.size();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.reg_list = list;
        bus.advance  = 1'b0;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.reg_list = ~list;
        k = 0;
        cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 80) begin
            adv = (adv_mode == 0) || (cyc % 3 == 0);
            if (k < n) begin
                check({tag, ".valid"},   bus.valid,   1);
                check({tag, ".busy"},    bus.busy,    1);
                check({tag, ".reg_num"}, bus.reg_num, exp_q[k]);
                check({tag, ".beat"},    bus.beat,    k);
                check({tag, ".first"},   bus.first,   (k == 0));
                check({tag, ".last"},    bus.last,    (k == n - 1));
                check({tag, ".count"},   bus.count,   n);
                check({tag, ".done"},    bus.done,    0);
            end else begin
                check({tag, ".done"},       bus.done,  1);
                check({tag, ".done_valid"}, bus.valid, 0);
                check({tag, ".done_busy"},  bus.busy,  1);
                check({tag, ".done_count"}, bus.count, n);
                done_seen = 1'b1;
            end
            if (poke && cyc == 1) begin
                bus.start    = 1'b1;
                bus.reg_list = 16'h000F;
            end else begin
                bus.start    = 1'b0;
            end
            bus.advance = adv;
            if (adv && k < n) k++;
            cyc++;
            @(negedge clk);
        end
        if (!done_seen) check({tag, ".timeout"}, 0, 1);
        bus.start   = 1'b0;
        bus.advance = 1'b0;
        check({tag, ".idle_busy"}, bus.busy, 0);
        check({tag, ".idle_done"}, bus.done, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.reg_list = '0;
        bus.advance  = 1'b0;

        #3;
        check("rst.busy",    bus.busy,    0);
        check("rst.valid",   bus.valid,   0);
        check("rst.reg_num", bus.reg_num, 0);
        check("rst.count",   bus.count,   0);
        check("rst.beat",    bus.beat,    0);
        check("rst.done",    bus.done,    0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        exp_q = '{0};
        run_list("single", 16'h0001, 0, 1'b0);

        exp_q = '{0, 5, 10, 15};
        run_list("spread", 16'h8421, 0, 1'b0);

        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        run_list("full_stall", 16'hFFFF, 1, 1'b0);

        exp_q = {};
        run_list("empty", 16'h0000, 0, 1'b0);

        exp_q = '{4, 5, 6, 7};
        run_list("restart_ignored", 16'h00F0, 0, 1'b1);

        // Abort mid-sequence with an asynchronous reset.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.reg_list = 16'h0F00;
        bus.advance  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort.beat0", bus.reg_num, 8);
        @(negedge clk);
        check("abort.beat1", bus.reg_num, 9);
        @(negedge clk);
        check("abort.beat2", bus.reg_num, 10);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort.busy",    bus.busy,    0);
        check("abort.valid",   bus.valid,   0);
        check("abort.reg_num", bus.reg_num, 0);
        check("abort.beat",    bus.beat,    0);
        check("abort.count",   bus.count,   0);
        check("abort.first",   bus.first,   0);
        check("abort.last",    bus.last,    0);
        check("abort.done",    bus.done,    0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort.no_done", bus.done, 0);
        end
        reset_n     = 1'b1;
        bus.advance = 1'b0;

        exp_q = '{0, 1};
        run_list("after_reset", 16'h0003, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
